// File: rtl/hv_timing_gen.sv
// rtl/hv_timing_gen.sv - horizontal/vertical video timing generator
//
// Purpose: produces pixel/line position plus sync, blanking and start flags
// for a raster display. Every output is registered and decoded from the very
// position it is presented with, so position and flags never skew.
//
// Ports:
//   CLK          system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   pix_en       pixel strobe; timing advances only when high
//   restart      synchronous frame restart request (held until next strobe)
//   hPos/vPos    current column / line
//   HSYNC/VSYNC  sync outputs, active level H_POL / V_POL
//   videoOn      high while the position is inside the visible area
//   line_start   high while hPos==0
//   frame_start  high while hPos==0 and vPos==0
//   frame_cnt    completed-frame counter, present only with HVT_FRAME_CNT_EN
//
// Build option: HVT_FRAME_CNT_EN adds the frame_cnt port and its counter.

module hv_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   HW       = 10,
   parameter int   VW       = 10
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          pix_en,
   input  logic          restart,
   output logic [HW-1:0] hPos,
   output logic [VW-1:0] vPos,
   output logic          HSYNC,
   output logic          VSYNC,
   output logic          videoOn,
   output logic          line_start,
   output logic          frame_start
`ifdef HVT_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Boundaries sized to the counters; every value here is < H_TOTAL / V_TOTAL
   // and therefore fits in HW / VW bits.
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] r_h_pos;
   logic [VW-1:0] r_v_pos;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_video_on;
   logic          r_line_start;
   logic          r_frame_start;
   logic          r_restart_pend;

   logic          w_restart;
   logic          w_to_origin;
   logic [HW-1:0] w_h_nxt;
   logic [VW-1:0] w_v_nxt;
   logic          w_video_on;
   logic          w_hsync_act;
   logic          w_vsync_act;

   // A restart seen while pix_en=0 is remembered so it wins over the
   // increment on the next strobe.
   assign w_restart = restart | r_restart_pend;

   // Position that the next strobe will present. Wraps are explicit compares
   // against the last column/line so non-power-of-two totals work.
   always_comb begin
      w_h_nxt     = r_h_pos;
      w_v_nxt     = r_v_pos;
      w_to_origin = 1'b0;
      if (w_restart) begin
         w_h_nxt     = '0;
         w_v_nxt     = '0;
         w_to_origin = 1'b1;
      end else if (r_h_pos == H_LAST) begin
         w_h_nxt = '0;
         if (r_v_pos == V_LAST) begin
            w_v_nxt     = '0;
            w_to_origin = 1'b1;
         end else begin
            w_v_nxt = r_v_pos + 1'b1;
         end
      end else begin
         w_h_nxt = r_h_pos + 1'b1;
      end
   end

   // Flags are decoded from the next position and registered alongside it,
   // which keeps them aligned with hPos/vPos. VSYNC only moves when vPos
   // does, i.e. together with the hPos wrap.
   assign w_video_on  = (w_h_nxt < H_VIS_END) && (w_v_nxt < V_VIS_END);
   assign w_hsync_act = (w_h_nxt >= H_SYNC_BEG) && (w_h_nxt < H_SYNC_END);
   assign w_vsync_act = (w_v_nxt >= V_SYNC_BEG) && (w_v_nxt < V_SYNC_END);

   // Reset parks on the last back-porch pixel of the last line so the first
   // strobe after release lands on (0,0).
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_h_pos        <= H_LAST;
         r_v_pos        <= V_LAST;
         r_hsync        <= ~H_POL;
         r_vsync        <= ~V_POL;
         r_video_on     <= 1'b0;
         r_line_start   <= 1'b0;
         r_frame_start  <= 1'b0;
         r_restart_pend <= 1'b0;
      end else if (pix_en) begin
         r_h_pos        <= w_h_nxt;
         r_v_pos        <= w_v_nxt;
         r_hsync        <= w_hsync_act ? H_POL : ~H_POL;
         r_vsync        <= w_vsync_act ? V_POL : ~V_POL;
         r_video_on     <= w_video_on;
         r_line_start   <= (w_h_nxt == '0);
         r_frame_start  <= (w_h_nxt == '0) && (w_v_nxt == '0);
         r_restart_pend <= 1'b0;
      end else if (restart) begin
         r_restart_pend <= 1'b1;
      end
   end

   assign hPos        = r_h_pos;
   assign vPos        = r_v_pos;
   assign HSYNC       = r_hsync;
   assign VSYNC       = r_vsync;
   assign videoOn     = r_video_on;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

`ifdef HVT_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;
   logic        r_origin_seen;

   // The first arrival at (0,0) after reset is the end of the parked reset
   // state, not a completed frame, so it only arms the counter.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt   <= '0;
         r_origin_seen <= 1'b0;
      end else if (pix_en && w_to_origin) begin
         r_origin_seen <= 1'b1;
         if (r_origin_seen) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign frame_cnt = r_frame_cnt;
`else
   logic w_unused;
   assign w_unused = w_to_origin;
`endif

endmodule

// File: tb/tb_hv_timing_gen.sv
// tb/tb_hv_timing_gen.sv - self-checking bench for hv_timing_gen

module tb_hv_timing_gen;

   typedef struct {
      logic [4:0]  h;
      logic [3:0]  v;
      logic        hs;
      logic        vs;
      logic        von;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   logic       CLK = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_en = 1'b0;
   logic       restart = 1'b0;
   logic [4:0] hPos;
   logic [3:0] vPos;
   logic       HSYNC;
   logic       VSYNC;
   logic       videoOn;
   logic       line_start;
   logic       frame_start;
`ifdef HVT_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int   n_assert = 0;
   int   n_fail = 0;
   exp_t q[$];

   // reference model state
   int   mh = 15;
   int   mv = 7;
   bit   pend = 1'b0;
   bit   first = 1'b1;
   int   fc = 0;

   hv_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .HW(5), .VW(4)
   ) dut (
      .CLK(CLK),
      .rst_n(rst_n),
      .pix_en(pix_en),
      .restart(restart),
      .hPos(hPos),
      .vPos(vPos),
      .HSYNC(HSYNC),
      .VSYNC(VSYNC),
      .videoOn(videoOn),
      .line_start(line_start),
      .frame_start(frame_start)
`ifdef HVT_FRAME_CNT_EN
      ,
      .frame_cnt(frame_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t expect_now();
      exp_t e;
      e.h   = 5'(mh);
      e.v   = 4'(mv);
      e.von = (mh < 8) && (mv < 4);
      e.hs  = !(mh >= 10 && mh <= 12);
      e.vs  = !(mv >= 5 && mv <= 6);
      e.ls  = (mh == 0);
      e.fs  = (mh == 0) && (mv == 0);
      e.fc  = 16'(fc);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (h=%0d v=%0d t=%0t)", tag, obs, expv, mh, mv, $time);
      end
   endtask

   task automatic check_outputs(input exp_t e);
      check("hPos",        32'(hPos),        32'(e.h));
      check("vPos",        32'(vPos),        32'(e.v));
      check("HSYNC",       32'(HSYNC),       32'(e.hs));
      check("VSYNC",       32'(VSYNC),       32'(e.vs));
      check("videoOn",     32'(videoOn),     32'(e.von));
      check("line_start",  32'(line_start),  32'(e.ls));
      check("frame_start", 32'(frame_start), 32'(e.fs));
`ifdef HVT_FRAME_CNT_EN
      check("frame_cnt",   32'(frame_cnt),   32'(e.fc));
`endif
   endtask

   task automatic model_reset();
      mh = 15; mv = 7; pend = 1'b0; first = 1'b1; fc = 0;
   endtask

   // drive one clock of stimulus, push the model's prediction, then pop and
   // compare after the edge
   task automatic step(input logic pe, input logic rs);
      bit   to0;
      exp_t e;
      pix_en  = pe;
      restart = rs;
      to0 = 1'b0;
      if (pe) begin
         if (rs || pend) begin
            mh = 0; mv = 0; pend = 1'b0; to0 = 1'b1;
         end else if (mh == 15) begin
            mh = 0;
            if (mv == 7) begin mv = 0; to0 = 1'b1; end
            else mv++;
         end else begin
            mh++;
         end
         if (to0) begin
            if (first) first = 1'b0;
            else fc = (fc + 1) & 16'hFFFF;
         end
      end else if (rs) begin
         pend = 1'b1;
      end
      q.push_back(expect_now());
      @(posedge CLK);
      #1;
      e = q.pop_front();
      check_outputs(e);
   endtask

   initial begin
      // reset state
      #12;
      model_reset();
      check_outputs(expect_now());
      @(posedge CLK);
      #1;
      rst_n = 1'b1;

      // first frame and wrap into the second: strobe 129 is (0,0) again
      for (int i = 0; i < 129; i++) step(1'b1, 1'b0);
      check("frame_start_s129", 32'(frame_start), 32'd1);

      // half-rate strobe: outputs must hold on pix_en=0 cycles
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         step(1'b0, 1'b0);
      end

      // walk to (5,2), then restart with pix_en low, strobe two cycles later
      for (int i = 0; i < 200 && !(mh == 5 && mv == 2); i++) step(1'b1, 1'b0);
      check("reach_h5", 32'(hPos), 32'd5);
      check("reach_v2", 32'(vPos), 32'd2);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("restart_fs", 32'(frame_start), 32'd1);

      // restart together with pix_en, mid-line
      for (int i = 0; i < 37; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);

      // walk to (9,6) and assert reset mid-cycle
      for (int i = 0; i < 200 && !(mh == 9 && mv == 6); i++) step(1'b1, 1'b0);
      check("reach_h9", 32'(hPos), 32'd9);
      check("reach_v6", 32'(vPos), 32'd6);
      pix_en  = 1'b0;
      restart = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs(expect_now());
      @(posedge CLK);
      #1;
      check_outputs(expect_now());
      rst_n = 1'b1;

      // three full frames from reset, then a restart mid-frame
      for (int i = 0; i < 385; i++) step(1'b1, 1'b0);
`ifdef HVT_FRAME_CNT_EN
      check("frame_cnt_3", 32'(frame_cnt), 32'd3);
`endif
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
`ifdef HVT_FRAME_CNT_EN
      check("frame_cnt_4", 32'(frame_cnt), 32'd4);
`endif
      step(1'b1, 1'b0);
      pix_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
